adc_pipe_ctrl: RTL and testbench
================================

ADC_PIPE_CTRL -- requirements
Module: adc_pipe_ctrl

Interface
REQ-001 Parameter: NUM_BITS, 3, ADC output width.
REQ-002 Parameter: NUM_STAGES, 2, number of encoder pipeline stages excluding the last stage.
REQ-003 Parameter: PHASE_W, 4, width of the timing configuration fields.
REQ-004 Port: clk_i, input, 1, single system clock; all logic on the rising edge.
REQ-005 Port: reset_i, input, 1, synchronous active-high reset.
REQ-006 Port: en_i, input, 1, run request for continuous conversion.
REQ-007 Port: t_phase_i, input, PHASE_W, phase-high duration in clk cycles; 0 is treated as 1.
REQ-008 Port: t_gap_i, input, PHASE_W, non-overlap gap in clk cycles; 0 is treated as 1.
REQ-009 Port: phi1_o / phi2_o, output, 1 each, non-overlapping phase clocks to the encoder.
REQ-010 Port: d_enc_i, input, NUM_BITS, encoder result.
REQ-011 Port: sample_o, output, NUM_BITS, captured conversion result.
REQ-012 Port: valid_o, output, 1 / ready_i, input, 1, output handshake.
REQ-013 Port: overrun_o, output, 1, sticky lost-sample flag / clr_ovr_i, input, 1, clears it.
REQ-014 Port: busy_o, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-015 FSM states: IDLE, P1, G1, P2, G2; phi1_o is registered high only in P1 and phi2_o only in P2.
REQ-016 IDLE->P1 when en_i=1; P1->G1 after tp cycles; G1->P2 after tg cycles; P2->G2 after tp cycles; G2->P1 after tg cycles if en_i=1, else G2->IDLE.
REQ-017 en_i is evaluated only in IDLE and at the end of G2; a started phi1/phi2 cycle always completes.
REQ-018 t_phase_i and t_gap_i are latched into shadow registers (tp, tg) on every entry to P1; changes take effect from the next cycle only.
REQ-019 phi1_o and phi2_o are never high in the same clk cycle; each gap is at least 1 cycle.
REQ-020 Capture phase: phi1 when NUM_STAGES is even, phi2 when odd; the capture event is the last cycle of the capture-phase state (P1 or P2).
REQ-021 Fill counter: the first floor(NUM_STAGES/2) capture events after IDLE->P1 are discarded; the counter is cleared on IDLE entry.
REQ-022 Post-fill capture event: if valid_o=0 or ready_i=1, sample_o<=d_enc_i and valid_o<=1 on the next edge.
REQ-023 Capture with valid_o=1 and ready_i=0: sample_o is held, the new sample is dropped, and overrun_o<=1.
REQ-024 ready_i=1 with no capture: valid_o<=0; sample_o holds its value.
REQ-025 overrun_o is cleared only by clr_ovr_i or reset; if set and clear coincide, set wins.
REQ-026 Entering IDLE does not flush an already-valid sample.

Reset
REQ-027 While reset_i=1 at a clk edge: state=IDLE; phi1_o=phi2_o=0; valid_o=0; sample_o=0; overrun_o=0; busy_o=0; timers, fill counter, tp, tg=0.
REQ-028 Reset mid-phase forces both phases low on the next edge, with no gap guarantee owed to the encoder; the encoder shares reset_i.

Structure
REQ-029 Shared package adc_pipe_pkg holds: the state enum, the NUM_STAGES derivation from NUM_BITS/NUM_BITS_PER_STAGE/REDUNDANCY/BITS_ADC_STAGE, the default PHASE_W, and a fill-depth function.
REQ-030 One sub-module, adc_pipe_phase_gen, contains the FSM, the timer and the shadow registers, and outputs phi1/phi2 plus a one-cycle capture strobe. Capture, fill and handshake logic live in the top level.

Verification
REQ-031 NUM_STAGES=2, t_phase=2, t_gap=1, en held at 1 -> phi1 2 cycles high, 1 low, phi2 2 high, 1 low, period 6; no cycle with both phases high.
REQ-032 t_phase=0, t_gap=0 -> behaves as 1/1, period 4.
REQ-033 Start from IDLE, ready_i=1 -> first capture discarded; valid_o first asserts after the 2nd phi1 pulse, with sample_o = d_enc_i from that pulse.
REQ-034 ready_i=0 for 2 captures -> first sample retained, overrun_o=1; clr_ovr_i pulse -> overrun_o=0.
REQ-035 en_i dropped mid-P1 -> cycle completes through G2, then IDLE; busy_o falls the cycle after G2 ends.
REQ-036 reset_i asserted during P2 -> next edge: phi2_o=0, valid_o=0, state IDLE; restart shows full fill discard again.

Source files
------------

// File: rtl/adc_pipe_pkg.sv
// adc_pipe_pkg: shared state enum, stage-count derivation, default widths and fill-depth helper
package adc_pipe_pkg;
    localparam int NUM_BITS_PER_STAGE = 1;
    localparam int REDUNDANCY = 1;
    localparam int BITS_ADC_STAGE = NUM_BITS_PER_STAGE + REDUNDANCY;
    localparam int DEF_NUM_BITS = 3;
    // the last stage resolves the non-redundant bits; the rest are split over pipeline stages
    localparam int DEF_NUM_STAGES = (DEF_NUM_BITS - (BITS_ADC_STAGE - REDUNDANCY)) / NUM_BITS_PER_STAGE;
    localparam int DEF_PHASE_W = 4;
    typedef enum logic [2:0] {IDLE, P1, G1, P2, G2} state_t;
    // one result emerges per phi1/phi2 pair, so a stage pair costs one discarded capture
    function automatic int fill_depth(input int stages);
        return stages / 2;
    endfunction
endpackage

// File: rtl/adc_pipe_ctrl_if.sv
// adc_pipe_ctrl_if: conversion result handshake (master: sample, valid out / ready in)
interface adc_pipe_ctrl_if #(parameter int NUM_BITS = adc_pipe_pkg::DEF_NUM_BITS);
    logic [NUM_BITS-1:0] sample;
    logic valid;
    logic ready;
    modport master (output sample, valid, input ready);
    modport slave (input sample, valid, output ready);
endinterface

// File: rtl/adc_pipe_phase_gen.sv
// adc_pipe_phase_gen: non-overlapping phi1/phi2 generator
// ports: clk_i, reset_i, en_i, t_phase_i/t_gap_i (0 means 1) in; phi1_o, phi2_o, cap_o (last cycle of capture phase), busy_o out
module adc_pipe_phase_gen
    import adc_pipe_pkg::*;
#(
    parameter int NUM_STAGES = DEF_NUM_STAGES,
    parameter int PHASE_W = DEF_PHASE_W
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    input  logic [PHASE_W-1:0] t_phase_i,
    input  logic [PHASE_W-1:0] t_gap_i,
    output logic               phi1_o,
    output logic               phi2_o,
    output logic               cap_o,
    output logic               busy_o
);
    localparam state_t CAP_ST = (NUM_STAGES % 2 == 0) ? P1 : P2;
    state_t r_state;
    logic [PHASE_W-1:0] r_cnt, r_tp, r_tg;
    logic r_phi1, r_phi2;
    logic [PHASE_W-1:0] w_tp, w_tg, w_lim;
    logic w_end, w_start;
    assign w_tp = (t_phase_i == '0) ? PHASE_W'(1) : t_phase_i;
    assign w_tg = (t_gap_i == '0) ? PHASE_W'(1) : t_gap_i;
    assign w_lim = (r_state == P1 || r_state == P2) ? r_tp : r_tg;
    assign w_end = r_cnt == w_lim - PHASE_W'(1);
    assign w_start = en_i && (r_state == IDLE || (r_state == G2 && w_end));
    assign phi1_o = r_phi1;
    assign phi2_o = r_phi2;
    assign cap_o = (r_state == CAP_ST) && w_end;
    assign busy_o = r_state != IDLE;
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= IDLE;
            r_cnt <= '0;
            r_tp <= '0;
            r_tg <= '0;
            r_phi1 <= 1'b0;
            r_phi2 <= 1'b0;
        end else begin
            r_cnt <= (w_end || r_state == IDLE) ? '0 : r_cnt + PHASE_W'(1);
            if (w_start) begin
                r_tp <= w_tp;
                r_tg <= w_tg;
            end
            case (r_state)
                IDLE: if (en_i) begin r_state <= P1; r_phi1 <= 1'b1; end
                P1: if (w_end) begin r_state <= G1; r_phi1 <= 1'b0; end
                G1: if (w_end) begin r_state <= P2; r_phi2 <= 1'b1; end
                P2: if (w_end) begin r_state <= G2; r_phi2 <= 1'b0; end
                G2: if (w_end) begin r_state <= en_i ? P1 : IDLE; r_phi1 <= en_i; end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/adc_pipe_ctrl.sv
// adc_pipe_ctrl: pipelined ADC phase control with pipeline-fill discard, result capture and handshake
// ports: clk_i, reset_i, en_i, t_phase_i, t_gap_i, d_enc_i, clr_ovr_i in; phi1_o, phi2_o, overrun_o, busy_o out; out_if result handshake
module adc_pipe_ctrl
    import adc_pipe_pkg::*;
#(
    parameter int NUM_BITS = DEF_NUM_BITS,
    parameter int NUM_STAGES = DEF_NUM_STAGES,
    parameter int PHASE_W = DEF_PHASE_W
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  en_i,
    input  logic [PHASE_W-1:0]    t_phase_i,
    input  logic [PHASE_W-1:0]    t_gap_i,
    output logic                  phi1_o,
    output logic                  phi2_o,
    input  logic [NUM_BITS-1:0]   d_enc_i,
    input  logic                  clr_ovr_i,
    output logic                  overrun_o,
    output logic                  busy_o,
    adc_pipe_ctrl_if.master       out_if
);
    localparam int FILL = fill_depth(NUM_STAGES);
    logic w_cap, w_busy, w_filled, w_take;
    logic [7:0] r_fill;
    logic [NUM_BITS-1:0] r_sample;
    logic r_valid, r_ovr;
    adc_pipe_phase_gen #(.NUM_STAGES(NUM_STAGES), .PHASE_W(PHASE_W)) u_phase_gen (
        .clk_i(clk_i),
        .reset_i(reset_i),
        .en_i(en_i),
        .t_phase_i(t_phase_i),
        .t_gap_i(t_gap_i),
        .phi1_o(phi1_o),
        .phi2_o(phi2_o),
        .cap_o(w_cap),
        .busy_o(w_busy)
    );
    assign w_filled = r_fill >= 8'(FILL);
    assign w_take = w_cap && w_filled;
    assign out_if.sample = r_sample;
    assign out_if.valid = r_valid;
    assign overrun_o = r_ovr;
    assign busy_o = w_busy;
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_fill <= '0;
            r_sample <= '0;
            r_valid <= 1'b0;
            r_ovr <= 1'b0;
        end else begin
            // idle clears the fill count so every restart discards the stale pipeline contents
            r_fill <= !w_busy ? '0 : (w_cap && !w_filled) ? r_fill + 8'd1 : r_fill;
            r_sample <= (w_take && (!r_valid || out_if.ready)) ? d_enc_i : r_sample;
            r_valid <= w_take ? 1'b1 : out_if.ready ? 1'b0 : r_valid;
            // a lost sample outranks a simultaneous clear
            r_ovr <= (w_take && r_valid && !out_if.ready) || (r_ovr && !clr_ovr_i);
        end
    end
endmodule

// File: tb/tb_adc_pipe_ctrl.sv
// tb_adc_pipe_ctrl: directed vector table plus corner-case sequences for adc_pipe_ctrl
module tb_adc_pipe_ctrl;
    logic clk = 1'b0;
    logic rst, en, clr;
    logic [3:0] tp, tg;
    logic [2:0] d;
    logic phi1, phi2, ovr, busy;
    int n_vec = 0;
    int n_err = 0;
    typedef struct {
        logic en, rdy, clr;
        logic [2:0] d;
        logic p1, p2, v;
        logic [2:0] s;
        logic ovr, busy;
    } vec_t;
    vec_t tbl[20];
    adc_pipe_ctrl_if #(.NUM_BITS(3)) bus ();
    adc_pipe_ctrl #(.NUM_BITS(3), .NUM_STAGES(2), .PHASE_W(4)) dut (
        .clk_i(clk),
        .reset_i(rst),
        .en_i(en),
        .t_phase_i(tp),
        .t_gap_i(tg),
        .phi1_o(phi1),
        .phi2_o(phi2),
        .d_enc_i(d),
        .clr_ovr_i(clr),
        .overrun_o(ovr),
        .busy_o(busy),
        .out_if(bus)
    );
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        en = 1'b0;
        clr = 1'b0;
        bus.ready = 1'b0;
        d = '0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pat(input logic [3:0] tpi, input logic [3:0] tgi, input int p, input int g, input int n);
        int m;
        do_reset();
        @(negedge clk);
        en = 1'b1;
        tp = tpi;
        tg = tgi;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            m = k % (2 * p + 2 * g);
            chk($sformatf("phase tp=%0d tg=%0d k=%0d", tpi, tgi, k), {14'd0, phi1, phi2},
                {14'd0, 1'(m < p), 1'(m >= p + g && m < 2 * p + g)});
        end
    endtask

    initial begin
        logic [2:0] eb[6];
        rst = 1'b1;
        en = 1'b0;
        clr = 1'b0;
        tp = 4'd2;
        tg = 4'd1;
        d = '0;
        bus.ready = 1'b0;
        // en rdy clr d | phi1 phi2 valid sample ovr busy
        tbl[0]  = '{1, 1, 0, 3'd0, 1, 0, 0, 3'd0, 0, 1};
        tbl[1]  = '{1, 1, 0, 3'd1, 1, 0, 0, 3'd0, 0, 1};
        tbl[2]  = '{1, 1, 0, 3'd2, 0, 0, 0, 3'd0, 0, 1};
        tbl[3]  = '{1, 1, 0, 3'd3, 0, 1, 0, 3'd0, 0, 1};
        tbl[4]  = '{1, 1, 0, 3'd4, 0, 1, 0, 3'd0, 0, 1};
        tbl[5]  = '{1, 1, 0, 3'd5, 0, 0, 0, 3'd0, 0, 1};
        tbl[6]  = '{1, 1, 0, 3'd6, 1, 0, 0, 3'd0, 0, 1};
        tbl[7]  = '{1, 1, 0, 3'd7, 1, 0, 0, 3'd0, 0, 1};
        tbl[8]  = '{1, 1, 0, 3'd5, 0, 0, 1, 3'd5, 0, 1};
        tbl[9]  = '{1, 0, 0, 3'd0, 0, 1, 1, 3'd5, 0, 1};
        tbl[10] = '{1, 0, 0, 3'd1, 0, 1, 1, 3'd5, 0, 1};
        tbl[11] = '{1, 0, 0, 3'd2, 0, 0, 1, 3'd5, 0, 1};
        tbl[12] = '{1, 0, 0, 3'd4, 1, 0, 1, 3'd5, 0, 1};
        tbl[13] = '{1, 0, 0, 3'd6, 1, 0, 1, 3'd5, 0, 1};
        tbl[14] = '{1, 0, 1, 3'd3, 0, 0, 1, 3'd5, 1, 1};
        tbl[15] = '{1, 1, 1, 3'd7, 0, 1, 0, 3'd5, 0, 1};
        tbl[16] = '{0, 0, 0, 3'd1, 0, 1, 0, 3'd5, 0, 1};
        tbl[17] = '{0, 0, 0, 3'd2, 0, 0, 0, 3'd5, 0, 1};
        tbl[18] = '{0, 0, 0, 3'd3, 0, 0, 0, 3'd5, 0, 0};
        tbl[19] = '{0, 1, 0, 3'd4, 0, 0, 0, 3'd5, 0, 0};
        repeat (2) @(posedge clk);
        #1;
        chk("reset state", {8'd0, phi1, phi2, bus.valid, bus.sample, ovr, busy}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            en = tbl[i].en;
            bus.ready = tbl[i].rdy;
            clr = tbl[i].clr;
            d = tbl[i].d;
            @(posedge clk);
            #1;
            chk($sformatf("row %0d", i), {8'd0, phi1, phi2, bus.valid, bus.sample, ovr, busy},
                {8'd0, tbl[i].p1, tbl[i].p2, tbl[i].v, tbl[i].s, tbl[i].ovr, tbl[i].busy});
        end
        pat(4'd2, 4'd1, 2, 1, 14);
        pat(4'd0, 4'd0, 1, 1, 10);
        // en dropped during P1: the cycle completes, then idle
        do_reset();
        @(negedge clk);
        en = 1'b1;
        tp = 4'd2;
        tg = 4'd1;
        @(posedge clk);
        #1;
        @(negedge clk);
        en = 1'b0;
        eb = '{3'b101, 3'b001, 3'b011, 3'b011, 3'b001, 3'b000};
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("en drop k=%0d phi1/phi2/busy", k + 1), {13'd0, phi1, phi2, busy}, {13'd0, eb[k]});
        end
        // reset during P2, then a restart must discard the first capture again
        do_reset();
        @(negedge clk);
        en = 1'b1;
        bus.ready = 1'b1;
        d = 3'd6;
        repeat (9) @(posedge clk);
        #1;
        chk("pre-reset valid/sample", {12'd0, bus.valid, bus.sample}, {12'd0, 1'b1, 3'd6});
        @(posedge clk);
        #1;
        chk("in P2 before reset", {14'd0, phi1, phi2}, 16'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("reset in P2", {9'd0, phi1, phi2, bus.valid, bus.sample, busy}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        d = 3'd1;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("restart k=%0d valid/sample", k), {12'd0, bus.valid, bus.sample},
                {12'd0, 1'(k == 9), (k == 9) ? 3'd1 : 3'd0});
            @(negedge clk);
            d = 3'(k + 1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
